// File: rtl/ram_loader.sv
// ram_loader: fills a 32-bit word RAM from an 8-bit byte stream.
// Bytes are packed little-endian into words and written to consecutive
// word addresses starting at a programmable base. While no load is
// running, the CPU write path passes straight through to the RAM.
module ram_loader #(
    parameter int DEPTH          = 10000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] base_addr,
    input  logic [31:0] word_count,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic        cpu_we,
    input  logic [31:0] cpu_address,
    input  logic [31:0] cpu_wd,
    output logic        cpu_stall,
    output logic        ram_we,
    output logic [31:0] ram_address,
    output logic [31:0] ram_wd,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COLLECT = 2'd1;
    localparam logic [1:0] WRITE   = 2'd2;

    // Idle-counter value on which the next empty cycle fires the timeout,
    // so the error flag rises exactly TIMEOUT_CYCLES cycles after a byte.
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
    localparam bit          TIMEOUT_ON   = (TIMEOUT_CYCLES != 0);

    logic [1:0]  state_reg,    state_next;
    logic [31:0] addr_reg,     addr_next;      // next RAM word address
    logic [31:0] count_reg,    count_next;     // words requested
    logic [31:0] written_reg,  written_next;   // words written so far
    logic [1:0]  byte_idx_reg, byte_idx_next;  // byte lane of next byte
    logic [31:0] word_reg,     word_next;      // word being assembled
    logic [31:0] idle_cnt_reg, idle_cnt_next;  // cycles since last byte
    logic        done_reg,     done_next;
    logic        error_reg,    error_next;

    // Range check uses a 33-bit end address so base+count cannot wrap.
    logic [32:0] end_addr;
    logic        out_of_range;
    logic        accept;

    assign end_addr     = {1'b0, base_addr} + {1'b0, word_count};
    assign out_of_range = (base_addr >= 32'(DEPTH)) || (end_addr > 33'(DEPTH));
    assign accept       = rx_valid && (state_reg == COLLECT);

    // Next-state and datapath update for the load sequencer.
    always_comb begin
        state_next    = state_reg;
        addr_next     = addr_reg;
        count_next    = count_reg;
        written_next  = written_reg;
        byte_idx_next = byte_idx_reg;
        word_next     = word_reg;
        idle_cnt_next = idle_cnt_reg;
        done_next     = done_reg;
        error_next    = error_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    done_next     = 1'b0;
                    error_next    = 1'b0;
                    addr_next     = base_addr;
                    count_next    = word_count;
                    written_next  = 32'd0;
                    byte_idx_next = 2'd0;
                    word_next     = 32'd0;
                    idle_cnt_next = 32'd0;
                    if (word_count == 32'd0) begin
                        done_next = 1'b1;
                    end else if (out_of_range) begin
                        error_next = 1'b1;
                    end else begin
                        state_next = COLLECT;
                    end
                end
            end

            COLLECT: begin
                if (accept) begin
                    word_next[{byte_idx_reg, 3'b000} +: 8] = rx_data;
                    byte_idx_next = byte_idx_reg + 2'd1;
                    idle_cnt_next = 32'd0;
                    if (byte_idx_reg == 2'd3) begin
                        state_next = WRITE;
                    end
                end else if (TIMEOUT_ON) begin
                    if (idle_cnt_reg == TIMEOUT_LAST) begin
                        // Stream went quiet: abandon the partial word.
                        state_next = IDLE;
                        error_next = 1'b1;
                    end else begin
                        idle_cnt_next = idle_cnt_reg + 32'd1;
                    end
                end
            end

            WRITE: begin
                written_next  = written_reg + 32'd1;
                addr_next     = addr_reg + 32'd1;
                byte_idx_next = 2'd0;
                idle_cnt_next = 32'd0;
                if (written_reg + 32'd1 == count_reg) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end else begin
                    state_next = COLLECT;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any partial word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            addr_reg     <= 32'd0;
            count_reg    <= 32'd0;
            written_reg  <= 32'd0;
            byte_idx_reg <= 2'd0;
            word_reg     <= 32'd0;
            idle_cnt_reg <= 32'd0;
            done_reg     <= 1'b0;
            error_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            addr_reg     <= addr_next;
            count_reg    <= count_next;
            written_reg  <= written_next;
            byte_idx_reg <= byte_idx_next;
            word_reg     <= word_next;
            idle_cnt_reg <= idle_cnt_next;
            done_reg     <= done_next;
            error_reg    <= error_next;
        end
    end

    // RAM bus mux: CPU pass-through when idle, loader registers otherwise.
    // CPU writes during a load are dropped, not queued.
    always_comb begin
        if (state_reg == IDLE) begin
            ram_we      = cpu_we;
            ram_address = cpu_address;
            ram_wd      = cpu_wd;
        end else begin
            ram_we      = (state_reg == WRITE);
            ram_address = addr_reg;
            ram_wd      = word_reg;
        end
    end

    assign rx_ready  = (state_reg == COLLECT);
    assign busy      = (state_reg != IDLE);
    assign cpu_stall = (state_reg != IDLE);
    assign done      = done_reg;
    assign error     = error_reg;

endmodule

// File: tb/tb_ram_loader.sv
// Directed testbench for ram_loader: basic load, pass-through, bounds,
// timeout, gapped stream with ignored start, and reset mid-load.
module tb_ram_loader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] base_addr;
    logic [31:0] word_count;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        cpu_we;
    logic [31:0] cpu_address;
    logic [31:0] cpu_wd;
    logic        cpu_stall;
    logic        ram_we;
    logic [31:0] ram_address;
    logic [31:0] ram_wd;
    logic        busy;
    logic        done;
    logic        error;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] mem [0:9999];
    logic [31:0] wa_q [$];
    logic [31:0] wd_q [$];

    ram_loader #(
        .DEPTH          (10000),
        .TIMEOUT_CYCLES (20)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .base_addr   (base_addr),
        .word_count  (word_count),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .cpu_we      (cpu_we),
        .cpu_address (cpu_address),
        .cpu_wd      (cpu_wd),
        .cpu_stall   (cpu_stall),
        .ram_we      (ram_we),
        .ram_address (ram_address),
        .ram_wd      (ram_wd),
        .busy        (busy),
        .done        (done),
        .error       (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model plus a log of every write seen on the bus.
    always @(posedge clk) begin
        if (rst_n && ram_we) begin
            wa_q.push_back(ram_address);
            wd_q.push_back(ram_wd);
            if (ram_address < 32'd10000) mem[ram_address] = ram_wd;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // Called at a negedge; returns at the negedge after the byte is taken.
    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check("byte_accept_timeout", 32'd1, 32'd0);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic pulse_start(input logic [31:0] b, input logic [31:0] c);
        base_addr  = b;
        word_count = c;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) check("idle_wait_timeout", 32'd1, 32'd0);
    endtask

    logic [7:0]  gb [0:11];
    logic [31:0] exp_w;

    initial begin
        rst_n       = 1'b0;
        start       = 1'b0;
        base_addr   = 32'd0;
        word_count  = 32'd0;
        rx_data     = 8'd0;
        rx_valid    = 1'b0;
        cpu_we      = 1'b0;
        cpu_address = 32'h0000_0123;
        cpu_wd      = 32'h0BAD_F00D;

        // Reset state
        #12;
        check("rst_rx_ready", 32'(rx_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_stall", 32'(cpu_stall), 32'd0);
        check("rst_pt_addr", ram_address, 32'h0000_0123);
        check("rst_pt_wd", ram_wd, 32'h0BAD_F00D);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Pass-through in IDLE
        cpu_we = 1'b1; cpu_address = 32'd5; cpu_wd = 32'hDEAD_BEEF;
        #1;
        check("pt_we", 32'(ram_we), 32'd1);
        check("pt_addr", ram_address, 32'd5);
        check("pt_wd", ram_wd, 32'hDEAD_BEEF);
        @(negedge clk);
        cpu_we = 1'b0;
        @(negedge clk);
        check("pt_mem5", mem[5], 32'hDEAD_BEEF);

        // Basic load, with a CPU write attempt that must be dropped
        wa_q.delete(); wd_q.delete();
        pulse_start(32'd10, 32'd2);
        check("load_busy", 32'(busy), 32'd1);
        check("load_stall", 32'(cpu_stall), 32'd1);
        cpu_we = 1'b1; cpu_address = 32'd7; cpu_wd = 32'h1234_5678;
        #1;
        check("load_cpu_we_dropped", 32'(ram_we), 32'd0);
        @(negedge clk);
        cpu_we = 1'b0;
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        send_byte(8'h55); send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
        wait_idle();
        check("load_nwrites", 32'(wa_q.size()), 32'd2);
        if (wa_q.size() == 2) begin
            check("load_a0", wa_q[0], 32'd10);
            check("load_d0", wd_q[0], 32'h4433_2211);
            check("load_a1", wa_q[1], 32'd11);
            check("load_d1", wd_q[1], 32'h8877_6655);
        end
        check("load_done", 32'(done), 32'd1);
        check("load_error", 32'(error), 32'd0);
        check("load_busy_end", 32'(busy), 32'd0);
        check("load_mem10", mem[10], 32'h4433_2211);
        check("load_mem11", mem[11], 32'h8877_6655);

        // Bounds: runs past end
        wa_q.delete(); wd_q.delete();
        pulse_start(32'd9999, 32'd2);
        check("oob_error", 32'(error), 32'd1);
        check("oob_done", 32'(done), 32'd0);
        check("oob_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("oob_nwrites", 32'(wa_q.size()), 32'd0);

        // Bounds: zero words
        pulse_start(32'd10, 32'd0);
        check("zero_done", 32'(done), 32'd1);
        check("zero_error", 32'(error), 32'd0);
        check("zero_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("zero_nwrites", 32'(wa_q.size()), 32'd0);

        // Bounds: last two words of the RAM
        pulse_start(32'd9998, 32'd2);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        send_byte(8'hA5); send_byte(8'hB6); send_byte(8'hC7); send_byte(8'hD8);
        wait_idle();
        check("edge_nwrites", 32'(wa_q.size()), 32'd2);
        check("edge_mem9998", mem[9998], 32'h0403_0201);
        check("edge_mem9999", mem[9999], 32'hD8C7_B6A5);
        check("edge_done", 32'(done), 32'd1);

        // Timeout: 2 bytes then silence; error exactly 20 cycles later
        wa_q.delete(); wd_q.delete();
        pulse_start(32'd20, 32'd1);
        send_byte(8'hAA); send_byte(8'hBB);
        repeat (19) @(negedge clk);
        check("to_error_early", 32'(error), 32'd0);
        check("to_busy_early", 32'(busy), 32'd1);
        @(negedge clk);
        check("to_error", 32'(error), 32'd1);
        check("to_busy", 32'(busy), 32'd0);
        check("to_done", 32'(done), 32'd0);
        check("to_nwrites", 32'(wa_q.size()), 32'd0);
        cpu_address = 32'd7;
        #1;
        check("to_pt_addr", ram_address, 32'd7);
        @(negedge clk);

        // Gapped stream with a start pulse mid-load
        wa_q.delete(); wd_q.delete();
        for (int i = 0; i < 12; i++) gb[i] = 8'(i * 19 + 5);
        pulse_start(32'd100, 32'd3);
        for (int i = 0; i < 12; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            if (i == 5) begin
                base_addr = 32'd0; word_count = 32'd1; start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            send_byte(gb[i]);
        end
        wait_idle();
        check("gap_nwrites", 32'(wa_q.size()), 32'd3);
        if (wa_q.size() == 3) begin
            for (int k = 0; k < 3; k++) begin
                exp_w = {gb[4*k+3], gb[4*k+2], gb[4*k+1], gb[4*k]};
                check($sformatf("gap_a%0d", k), wa_q[k], 32'd100 + 32'(k));
                check($sformatf("gap_d%0d", k), wd_q[k], exp_w);
            end
        end
        check("gap_done", 32'(done), 32'd1);

        // Reset after 3 bytes of a word
        wa_q.delete(); wd_q.delete();
        pulse_start(32'd50, 32'd1);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        rst_n = 1'b0;
        #1;
        check("mr_busy", 32'(busy), 32'd0);
        check("mr_rx_ready", 32'(rx_ready), 32'd0);
        check("mr_stall", 32'(cpu_stall), 32'd0);
        check("mr_ram_we", 32'(ram_we), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("mr_nwrites", 32'(wa_q.size()), 32'd0);
        pulse_start(32'd0, 32'd1);
        send_byte(8'hA1); send_byte(8'hB2); send_byte(8'hC3); send_byte(8'hD4);
        wait_idle();
        check("mr2_nwrites", 32'(wa_q.size()), 32'd1);
        if (wa_q.size() == 1) begin
            check("mr2_a0", wa_q[0], 32'd0);
            check("mr2_d0", wd_q[0], 32'hD4C3_B2A1);
        end
        check("mr2_done", 32'(done), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
